// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers of a 5-stage MIPS pipeline.
// Applies the hazard unit's stall, flush and redirect decisions, and counts stall cycles.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CTRL_W   = 12,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushE,
  input  logic [1:0]        PCSrcD,
  input  logic [31:0]       PCBranchD,
  input  logic [31:0]       PCJumpD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RdD,
  input  logic [31:0]       SignImmD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [4:0]        RsE,
  output logic [4:0]        RtE,
  output logic [4:0]        RdE,
  output logic [31:0]       SignImmE,
  output logic              ValidE,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        redir;
  logic [31:0] pcPlus4F;
  logic [31:0] pcTarget;

  // A stalled decode cannot redirect: its branch outcome is not resolved yet.
  assign redir    = (PCSrcD != 2'd0) && !StallD;
  assign pcPlus4F = PCF + 32'd4;

  always_comb begin
    pcTarget = pcPlus4F;
    case (PCSrcD)
      2'd1:    pcTarget = PCBranchD;
      2'd2:    pcTarget = PCJumpD;
      2'd3:    pcTarget = RD1D;
      default: pcTarget = pcPlus4F;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= redir ? pcTarget : pcPlus4F;
    end
  end

  // No delay slot: a redirect kills the wrong-path instruction in IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (redir) begin
        InstrD   <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end else begin
        InstrD   <= InstrF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
      end
    end
  end

  // A decode stall bubbles EX so the held instruction issues only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CtrlE    <= '0;
      RD1E     <= 32'd0;
      RD2E     <= 32'd0;
      RsE      <= 5'd0;
      RtE      <= 5'd0;
      RdE      <= 5'd0;
      SignImmE <= 32'd0;
      ValidE   <= 1'b0;
    end else if (FlushE || StallD) begin
      CtrlE    <= '0;
      RD1E     <= 32'd0;
      RD2E     <= 32'd0;
      RsE      <= 5'd0;
      RtE      <= 5'd0;
      RdE      <= 5'd0;
      SignImmE <= 32'd0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
      SignImmE <= SignImmD;
      ValidE   <= ValidD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (StallF && (StallCnt != CNT_MAX)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: free run, load-use stall, branch, jump, jr,
// PC wrap, counter saturation and asynchronous reset mid-stall.
module tb_pipe_stage_regs;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              StallF, StallD, FlushE;
  logic [1:0]        PCSrcD;
  logic [31:0]       PCBranchD, PCJumpD, RD1D, RD2D, InstrF, SignImmD;
  logic [CTRL_W-1:0] CtrlD;
  logic [4:0]        RsD, RtD, RdD;
  logic [31:0]       PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
  logic              ValidD, ValidE;
  logic [CTRL_W-1:0] CtrlE;
  logic [4:0]        RsE, RtE, RdE;
  logic [CNT_W-1:0]  StallCnt;

  int total = 0;
  int bad   = 0;
  int expCnt;

  pipe_stage_regs #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .RD1D(RD1D),
    .RD2D(RD2D), .InstrF(InstrF), .CtrlD(CtrlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
    .SignImmD(SignImmD), .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .RsE(RsE),
    .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE), .ValidE(ValidE), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrAt(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkVal({tag, " PCF"}, PCF, 32'h0);
    checkVal({tag, " InstrD"}, InstrD, 32'h0);
    checkVal({tag, " PCPlus4D"}, PCPlus4D, 32'h0);
    checkVal({tag, " ValidD"}, 32'(ValidD), 32'h0);
    checkVal({tag, " CtrlE"}, 32'(CtrlE), 32'h0);
    checkVal({tag, " RD1E"}, RD1E, 32'h0);
    checkVal({tag, " ValidE"}, 32'(ValidE), 32'h0);
    checkVal({tag, " StallCnt"}, 32'(StallCnt), 32'h0);
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0; PCSrcD = 2'd0;
    PCBranchD = 32'h0; PCJumpD = 32'h0; RD1D = 32'h1111_1111; RD2D = 32'h2222_2222;
    InstrF = instrAt(32'h0); CtrlD = 12'hABC; RsD = 5'd3; RtD = 5'd5; RdD = 5'd7;
    SignImmD = 32'hFFFF_FF80;
    #3;
    checkReset("reset");
    #5 rst = 1'b0;

    // free run: 0 -> 4 -> 8 -> C -> 10
    InstrF = instrAt(32'h0); tick;
    checkVal("run1 PCF", PCF, 32'h4);
    checkVal("run1 InstrD", InstrD, instrAt(32'h0));
    checkVal("run1 ValidD", 32'(ValidD), 32'h1);
    checkVal("run1 ValidE", 32'(ValidE), 32'h0);
    InstrF = instrAt(32'h4); tick;
    checkVal("run2 PCF", PCF, 32'h8);
    checkVal("run2 ValidE", 32'(ValidE), 32'h1);
    checkVal("run2 CtrlE", 32'(CtrlE), 32'hABC);
    checkVal("run2 RD2E", RD2E, 32'h2222_2222);
    checkVal("run2 RdE", 32'(RdE), 32'h7);
    checkVal("run2 SignImmE", SignImmE, 32'hFFFF_FF80);
    InstrF = instrAt(32'h8); tick;
    checkVal("run3 PCF", PCF, 32'hC);
    InstrF = instrAt(32'hC); tick;
    checkVal("run4 PCF", PCF, 32'h10);
    checkVal("run4 InstrD", InstrD, instrAt(32'hC));
    checkVal("run4 PCPlus4D", PCPlus4D, 32'h10);

    // load-use stall at 0x10
    StallF = 1'b1; StallD = 1'b1; InstrF = instrAt(32'h10); tick;
    checkVal("lu PCF", PCF, 32'h10);
    checkVal("lu InstrD", InstrD, instrAt(32'hC));
    checkVal("lu ValidE", 32'(ValidE), 32'h0);
    checkVal("lu CtrlE", 32'(CtrlE), 32'h0);
    checkVal("lu RsE", 32'(RsE), 32'h0);
    checkVal("lu StallCnt", 32'(StallCnt), 32'h1);
    StallF = 1'b0; StallD = 1'b0; tick;
    checkVal("lu2 PCF", PCF, 32'h14);
    checkVal("lu2 InstrD", InstrD, instrAt(32'h10));
    checkVal("lu2 ValidE", 32'(ValidE), 32'h1);

    // taken branch with EX flush
    PCSrcD = 2'd1; PCBranchD = 32'h40; FlushE = 1'b1; InstrF = instrAt(32'h14); tick;
    checkVal("br PCF", PCF, 32'h40);
    checkVal("br InstrD", InstrD, 32'h0);
    checkVal("br PCPlus4D", PCPlus4D, 32'h0);
    checkVal("br ValidD", 32'(ValidD), 32'h0);
    checkVal("br ValidE", 32'(ValidE), 32'h0);
    PCSrcD = 2'd0; FlushE = 1'b0; InstrF = instrAt(32'h40); tick;
    checkVal("br2 PCF", PCF, 32'h44);
    checkVal("br2 InstrD", InstrD, instrAt(32'h40));
    checkVal("br2 ValidD", 32'(ValidD), 32'h1);
    checkVal("br2 ValidE", 32'(ValidE), 32'h0);

    // jump ignored while stalled, taken once the stall drops
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 2'd2; PCJumpD = 32'h100;
    InstrF = instrAt(32'h44); tick;
    checkVal("jst PCF", PCF, 32'h44);
    checkVal("jst ValidD", 32'(ValidD), 32'h1);
    checkVal("jst StallCnt", 32'(StallCnt), 32'h2);
    StallF = 1'b0; StallD = 1'b0; tick;
    checkVal("jmp PCF", PCF, 32'h100);
    checkVal("jmp ValidD", 32'(ValidD), 32'h0);
    checkVal("jmp ValidE", 32'(ValidE), 32'h1);
    checkVal("jmp RD1E", RD1E, 32'h1111_1111);

    // jr, then wrap from 0xFFFF_FFFC
    PCSrcD = 2'd3; RD1D = 32'h2000; tick;
    checkVal("jr PCF", PCF, 32'h2000);
    RD1D = 32'hFFFF_FFFC; tick;
    checkVal("jr2 PCF", PCF, 32'hFFFF_FFFC);
    PCSrcD = 2'd0; InstrF = instrAt(32'hFFFF_FFFC); tick;
    checkVal("wrap PCF", PCF, 32'h0);
    checkVal("wrap PCPlus4D", PCPlus4D, 32'h0);
    checkVal("wrap ValidD", 32'(ValidD), 32'h1);

    // StallF with FlushE: PC holds, E bubbles, IF/ID still loads
    StallF = 1'b1; FlushE = 1'b1; InstrF = instrAt(32'h0); tick;
    checkVal("sf PCF", PCF, 32'h0);
    checkVal("sf ValidE", 32'(ValidE), 32'h0);
    checkVal("sf RD2E", RD2E, 32'h0);
    checkVal("sf InstrD", InstrD, instrAt(32'h0));
    checkVal("sf StallCnt", 32'(StallCnt), 32'h3);

    // counter saturation
    FlushE = 1'b0; expCnt = 3;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      tick;
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      checkVal("sat StallCnt", 32'(StallCnt), 32'(expCnt));
    end
    checkVal("sat PCF", PCF, 32'h0);

    // async reset mid-stall takes effect before the next edge
    rst = 1'b1; #1;
    checkReset("midrst");
    @(negedge clk);
    StallF = 1'b0; rst = 1'b0; InstrF = instrAt(32'h0);
    checkVal("rel PCF", PCF, 32'h0);
    tick;
    checkVal("rel2 PCF", PCF, 32'h4);
    checkVal("rel2 InstrD", InstrD, instrAt(32'h0));
    checkVal("rel2 StallCnt", 32'(StallCnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
